// File: rtl/mem_access.sv
// mem_access: load/store unit with RAM byte lanes, a 1 KiB MMIO window (LED, switches)
// and a two-state FSM that stalls one cycle per load for the synchronous RAM.
module mem_access #(
    parameter int          RAM_AW  = 14,
    parameter logic [31:0] IO_BASE = 32'hFFFF_FC00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    input  logic [31:0]       ram_rdata,
    input  logic [15:0]       switch_in,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_we,
    output logic [15:0]       led_out,
    output logic [31:0]       load_data,
    output logic              stall,
    output logic              misalign
);
    typedef enum logic {IDLE, RD_WAIT} state_t;
    state_t state;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic        io_q;
    logic [31:0] io_data_q;
    logic        is_io, led_hit, sw_hit, bad, mis, st, issue;
    logic [31:0] word, shifted, ext;
    logic [15:0] half;
    logic [7:0]  byte_v;

    assign is_io   = addr[31:10] == IO_BASE[31:10];
    assign led_hit = is_io && addr[9:0] == 10'h060;
    assign sw_hit  = is_io && addr[9:0] == 10'h070;
    assign bad     = funct3[1:0] == 2'b11 || (funct3[2] && funct3[1]);
    assign mis     = bad || (funct3[1:0] == 2'b01 && addr[0]) ||
                     (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    assign misalign = !rst && (mem_read || mem_write) && mis;
    assign st       = !rst && mem_write && !mis;
    assign issue    = !rst && state == IDLE && mem_read && !mem_write && !mis;
    assign stall    = issue;
    assign ram_addr = addr[RAM_AW+1:2];

    assign ram_wdata = funct3[1:0] == 2'b00 ? {4{store_data[7:0]}} :
                       funct3[1:0] == 2'b01 ? {2{store_data[15:0]}} : store_data;
    assign ram_we    = (!st || is_io)        ? 4'b0000 :
                       funct3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
                       funct3[1:0] == 2'b01 ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;

    // Extraction uses the lane and size captured at issue, not the live inputs.
    assign word    = io_q ? io_data_q : ram_rdata;
    assign shifted = word >> {lane_q, 3'b000};
    assign byte_v  = shifted[7:0];
    assign half    = lane_q[1] ? word[31:16] : word[15:0];
    assign ext     = f3_q[1:0] == 2'b00 ? {{24{!f3_q[2] && byte_v[7]}}, byte_v} :
                     f3_q[1:0] == 2'b01 ? {{16{!f3_q[2] && half[15]}}, half} : word;
    assign load_data = (!rst && state == RD_WAIT) ? ext : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            led_out   <= 16'h0;
            f3_q      <= 3'b000;
            lane_q    <= 2'b00;
            io_q      <= 1'b0;
            io_data_q <= 32'h0;
        end else begin
            state <= issue ? RD_WAIT : IDLE;
            if (issue) begin
                f3_q      <= funct3;
                lane_q    <= addr[1:0];
                io_q      <= is_io;
                io_data_q <= sw_hit ? {16'h0, switch_in} : led_hit ? {16'h0, led_out} : 32'h0;
            end
            if (st && led_hit)
                led_out <= funct3[1:0] == 2'b00 ? {led_out[15:8], store_data[7:0]} : store_data[15:0];
        end
    end
endmodule
